// File: rtl/knn_dist_core_pkg.sv
// Shared widths and constants for the KNN squared-distance datapath.
package knn_dist_core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DIST_W_DEF = 2 * DATA_W_DEF;

  localparam logic [DIST_W_DEF-1:0] DIST_ZERO = '0;

endpackage

// File: rtl/knn_absdiff_sq.sv
// Squared absolute difference of two unsigned operands, exact to 2*DATA_W bits.
module knn_absdiff_sq
  import knn_dist_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] sq
);

  logic [DATA_W-1:0]   diff;
  logic [2*DATA_W-1:0] diff_ext;

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    diff = '0;
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
  end

  assign diff_ext = {{DATA_W{1'b0}}, diff};
  assign sq       = diff_ext * diff_ext;

endmodule

// File: rtl/knn_dist_core.sv
// Combinational squared-Euclidean distance between two 2-D points, forced to zero in reset.
module knn_dist_core
  import knn_dist_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                KNN_ENABLE,
  input  logic [DATA_W-1:0]   x1,
  input  logic [DATA_W-1:0]   x2,
  input  logic [DATA_W-1:0]   y1,
  input  logic [DATA_W-1:0]   y2,
  output logic [2*DATA_W-1:0] z
);

  localparam int DIST_W = 2 * DATA_W;

  logic [DIST_W-1:0] sx;
  logic [DIST_W-1:0] sy;
  logic [DIST_W-1:0] dist_sum;

  // clk and KNN_ENABLE exist only for wrapper port compatibility.
  logic unused_ports;
  assign unused_ports = &{1'b0, clk, KNN_ENABLE};

  knn_absdiff_sq #(.DATA_W(DATA_W)) u_sq_x (
    .a  (x1),
    .b  (x2),
    .sq (sx)
  );

  knn_absdiff_sq #(.DATA_W(DATA_W)) u_sq_y (
    .a  (y1),
    .b  (y2),
    .sq (sy)
  );

  // Carry out of the final add is dropped: result is modulo 2^DIST_W.
  assign dist_sum = sx + sy;

  always_comb begin
    z = dist_sum;
    if (rst) begin
      z = DIST_W'(DIST_ZERO);
    end
  end

endmodule

// File: tb/tb_knn_dist_core.sv
// Directed and random checks of the combinational KNN squared-distance core.
module tb_knn_dist_core;

  logic        clk;
  logic        rst;
  logic        knn_enable;
  logic [31:0] x1, x2, y1, y2;
  logic [63:0] z;

  int n_checks;
  int n_fail;

  logic [63:0] dut_res [100];
  logic [63:0] ref_res [100];

  knn_dist_core #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .KNN_ENABLE (knn_enable),
    .x1         (x1),
    .x2         (x2),
    .y1         (y1),
    .y2         (y2),
    .z          (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] b1, input logic [31:0] b2);
    x1 = a1; x2 = a2; y1 = b1; y2 = b2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'd3, 32'd0, 32'd4, 32'd0);
    n_checks++;
    if (z !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_hold: z=%0d required 0", z);
    end
    drive(32'd999, 32'd0, 32'd0, 32'd999);
    n_checks++;
    if (z !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_input_change: z=%0d required 0", z);
    end
    $display("reset: z=%0d", z);
  endtask

  task automatic test_reset_release();
    rst = 1'b1;
    drive(32'd3, 32'd0, 32'd4, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (z !== 64'd25) begin
      n_fail++;
      $display("FAIL reset_release: z=%0d required 25", z);
    end
    $display("reset_release: z=%0d", z);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (z !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_async_assert: z=%0d required 0", z);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] tx1 [5];
    logic [31:0] tx2 [5];
    logic [31:0] ty1 [5];
    logic [31:0] ty2 [5];
    logic [63:0] texp [5];
    tx1 = '{32'd3, 32'd0, 32'd500, 32'd0,   32'd1000};
    tx2 = '{32'd0, 32'd3, 32'd500, 32'd999, 32'd7};
    ty1 = '{32'd4, 32'd0, 32'd500, 32'd999, 32'd2};
    ty2 = '{32'd0, 32'd4, 32'd500, 32'd0,   32'd9};
    texp = '{64'd25, 64'd25, 64'd0, 64'd1996002, 64'd986098};
    for (int i = 0; i < 5; i++) begin
      drive(tx1[i], tx2[i], ty1[i], ty2[i]);
      n_checks++;
      if (z !== texp[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: z=%0d required %0d", i, z, texp[i]);
      end
      $display("directed %0d: %0d %0d %0d %0d -> z=%0d", i, tx1[i], tx2[i], ty1[i], ty2[i], z);
    end
  endtask

  task automatic test_width_limit();
    drive(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0);
    n_checks++;
    if (z !== 64'hFFFF_FFFC_0000_0002) begin
      n_fail++;
      $display("FAIL width_wrap: z=%h required fffffffc00000002", z);
    end
    $display("width_wrap: z=%h", z);
    drive(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    n_checks++;
    if (z !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL width_x_only: z=%h required fffffffe00000001", z);
    end
    $display("width_x_only: z=%h", z);
    drive(32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5);
    n_checks++;
    if (z !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL width_x_swapped: z=%h required fffffffe00000001", z);
    end
    $display("width_x_swapped: z=%h", z);
  endtask

  task automatic test_enable();
    logic [63:0] expv;
    expv = 64'd25;
    for (int i = 0; i < 4; i++) begin
      knn_enable = i[0];
      drive(32'd10, 32'd7, 32'd1, 32'd5);
      n_checks++;
      if (z !== expv) begin
        n_fail++;
        $display("FAIL enable_%0d: z=%0d required %0d", i, z, expv);
      end
      $display("enable=%0b: z=%0d", knn_enable, z);
    end
    knn_enable = 1'b0;
  endtask

  task automatic test_random_sweep();
    int a1, a2, b1, b2, dx, dy;
    logic [63:0] tmp;
    knn_enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      a1 = int'($urandom_range(999, 0));
      a2 = int'($urandom_range(999, 0));
      b1 = int'($urandom_range(999, 0));
      b2 = int'($urandom_range(999, 0));
      dx = a1 - a2;
      dy = b1 - b2;
      ref_res[i] = 64'(dx * dx + dy * dy);
      drive(32'(a1), 32'(a2), 32'(b1), 32'(b2));
      dut_res[i] = z;
      n_checks++;
      if (z !== ref_res[i]) begin
        n_fail++;
        $display("FAIL random_%0d: z=%0d required %0d", i, z, ref_res[i]);
      end
      $display("random %0d: %0d %0d %0d %0d -> z=%0d", i, a1, a2, b1, b2, z);
    end
    for (int i = 0; i < 99; i++) begin
      for (int j = 0; j < 99 - i; j++) begin
        if (dut_res[j] > dut_res[j+1]) begin
          tmp = dut_res[j]; dut_res[j] = dut_res[j+1]; dut_res[j+1] = tmp;
        end
        if (ref_res[j] > ref_res[j+1]) begin
          tmp = ref_res[j]; ref_res[j] = ref_res[j+1]; ref_res[j+1] = tmp;
        end
      end
    end
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (dut_res[i] !== ref_res[i] || (i > 0 && dut_res[i] < dut_res[i-1])) begin
        n_fail++;
        $display("FAIL sorted_%0d: z=%0d required %0d", i, dut_res[i], ref_res[i]);
      end
    end
    $display("sorted: min=%0d max=%0d", dut_res[0], dut_res[99]);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    knn_enable = 1'b0;
    x1 = '0; x2 = '0; y1 = '0; y2 = '0;
    test_reset();
    test_reset_release();
    test_directed();
    test_width_limit();
    test_enable();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
